imem_loader: RTL and testbench

- Boot-time program loader; the hardware counterpart of bench-side instruction preloading.
- Accepts a byte stream over a valid/ready handshake and assembles bytes MSB-first into 32-bit instruction words.
- Writes each word into the instruction memory's write port at consecutive word addresses from 0, then asserts start to the CPU.
- Sits between an external byte source (UART/debug link) and the CPU's instruction memory and start_i input.

---
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader.
// Collects a byte stream (MSB first) into 32-bit instruction words, writes
// each word to consecutive instruction-memory addresses starting at 0, and
// raises start_o for the CPU once the byte flagged as last completes a word.
//
// Byte handshake: a byte transfers on a rising edge where byte_valid_i and
// byte_ready_o are both high; byte_data_i and byte_last_i are only looked at
// on those edges. The source must hold its byte stable until it transfers.
//
// dbg_state_o exposes the FSM state: 0 LOAD, 1 WRITE, 2 DONE, 3 ERROR.
module imem_loader #(
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  byte_valid_i,
   input  logic [7:0]            byte_data_i,
   input  logic                  byte_last_i,
   output logic                  byte_ready_o,
   output logic                  imem_we_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   output logic [31:0]           imem_data_o,
   output logic                  start_o,
   output logic                  busy_o,
   output logic                  err_o,
   output logic [ADDR_WIDTH:0]   word_count_o,
   output logic [1:0]            dbg_state_o
);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

   state_t                state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic [31:0]           shift_q, shift_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  last_q, last_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]           wr_data_q, wr_data_d;

   logic ready_c, we_c, busy_c, start_c, err_c;

   // State and datapath registers; reset leaves memory contents untouched.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= S_LOAD;
         idx_q     <= 2'd0;
         shift_q   <= 32'd0;
         addr_q    <= '0;
         count_q   <= '0;
         last_q    <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         count_q   <= count_d;
         last_q    <= last_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Next-state logic and per-state outputs.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      addr_d    = addr_q;
      count_d   = count_q;
      last_d    = last_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      ready_c   = 1'b0;
      we_c      = 1'b0;
      busy_c    = 1'b0;
      start_c   = 1'b0;
      err_c     = 1'b0;

      case (state_q)
         S_LOAD: begin
            ready_c = 1'b1;
            busy_c  = 1'b1;
            if (byte_valid_i) begin
               shift_d = {shift_q[23:0], byte_data_i};
               idx_d   = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  // Word complete: capture address/data now so the write
                  // port holds them through WRITE and afterwards.
                  state_d   = S_WRITE;
                  last_d    = byte_last_i;
                  wr_addr_d = addr_q;
                  wr_data_d = {shift_q[23:0], byte_data_i};
               end else if (byte_last_i) begin
                  // Program ended mid-word: drop the partial word.
                  state_d = S_ERROR;
               end
            end
         end
         S_WRITE: begin
            we_c    = 1'b1;
            busy_c  = 1'b1;
            addr_d  = addr_q + ADDR_ONE;
            count_d = count_q + CNT_ONE;
            if (last_q) begin
               state_d = S_DONE;
            end else if (addr_q == ADDR_MAX) begin
               // Memory full and more program follows.
               state_d = S_ERROR;
            end else begin
               state_d = S_LOAD;
            end
         end
         S_DONE: begin
            start_c = 1'b1;
         end
         S_ERROR: begin
            err_c = 1'b1;
         end
         default: begin
            state_d = S_ERROR;
         end
      endcase
   end

   assign byte_ready_o = ready_c;
   assign imem_we_o    = we_c;
   assign imem_addr_o  = wr_addr_q;
   assign imem_data_o  = wr_data_q;
   assign start_o      = start_c;
   assign busy_o       = busy_c;
   assign err_o        = err_c;
   assign word_count_o = count_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (128-word and 4-word memories) share
// one byte stream and are checked every cycle against a behavioural model.
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_last;

   logic        rdy0, we0, start0, busy0, err0;
   logic [6:0]  addr0;
   logic [31:0] data0;
   logic [7:0]  cnt0;
   logic [1:0]  st0;
   logic        rdy1, we1, start1, busy1, err1;
   logic [1:0]  addr1;
   logic [31:0] data1;
   logic [2:0]  cnt1;
   logic [1:0]  st1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_wr0    = 0;
   int n_wr1    = 0;
   bit cmp_en   = 1'b0;
   bit sb_on    = 1'b0;
   logic [38:0] exp_q[$];

   // model state per instance
   int          depth [2] = '{128, 4};
   int          m_bytes [2];
   int          m_words [2];
   logic [31:0] m_word [2];
   bit          m_pend [2];
   bit          m_done [2];
   bit          m_err [2];
   bit          m_last [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_data [2];

   imem_loader #(.ADDR_WIDTH(7)) dut0 (
      .clk_i(clk), .rst_i(rst_n), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
      .byte_last_i(byte_last), .byte_ready_o(rdy0), .imem_we_o(we0), .imem_addr_o(addr0),
      .imem_data_o(data0), .start_o(start0), .busy_o(busy0), .err_o(err0),
      .word_count_o(cnt0), .dbg_state_o(st0)
   );

   imem_loader #(.ADDR_WIDTH(2)) dut1 (
      .clk_i(clk), .rst_i(rst_n), .byte_valid_i(byte_valid), .byte_data_i(byte_data),
      .byte_last_i(byte_last), .byte_ready_o(rdy1), .imem_we_o(we1), .imem_addr_o(addr1),
      .imem_data_o(data1), .start_o(start1), .busy_o(busy1), .err_o(err1),
      .word_count_o(cnt1), .dbg_state_o(st1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      m_bytes[k] = 0;
      m_words[k] = 0;
      m_word[k]  = 32'd0;
      m_pend[k]  = 1'b0;
      m_done[k]  = 1'b0;
      m_err[k]   = 1'b0;
      m_last[k]  = 1'b0;
      m_addr[k]  = 32'd0;
      m_data[k]  = 32'd0;
   endtask

   // Advance the model across the coming rising edge using the current inputs.
   task automatic model_step(input int k);
      if (!rst_n) begin
         model_reset(k);
      end else if (m_pend[k]) begin
         m_pend[k]  = 1'b0;
         m_words[k] = m_words[k] + 1;
         if (m_last[k]) m_done[k] = 1'b1;
         else if (m_words[k] == depth[k]) m_err[k] = 1'b1;
      end else if (!m_done[k] && !m_err[k] && byte_valid) begin
         m_word[k]  = {m_word[k][23:0], byte_data};
         m_bytes[k] = m_bytes[k] + 1;
         if (m_bytes[k] == 4) begin
            m_bytes[k] = 0;
            m_pend[k]  = 1'b1;
            m_last[k]  = byte_last;
            m_addr[k]  = m_words[k] % depth[k];
            m_data[k]  = m_word[k];
         end else if (byte_last) begin
            m_err[k] = 1'b1;
         end
      end
   endtask

   task automatic cmp_dut(input int k, input logic rdy, input logic we, input logic start,
                          input logic busy, input logic err, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] cnt, input logic [31:0] st);
      logic [31:0] exp_st;
      exp_st = m_err[k] ? 32'd3 : m_done[k] ? 32'd2 : m_pend[k] ? 32'd1 : 32'd0;
      chk("ready", k, {31'd0, rdy}, {31'd0, !(m_pend[k] || m_done[k] || m_err[k])});
      chk("we", k, {31'd0, we}, {31'd0, m_pend[k]});
      chk("start", k, {31'd0, start}, {31'd0, m_done[k]});
      chk("busy", k, {31'd0, busy}, {31'd0, !(m_done[k] || m_err[k])});
      chk("err", k, {31'd0, err}, {31'd0, m_err[k]});
      chk("addr", k, addr, m_addr[k]);
      chk("data", k, data, m_data[k]);
      chk("count", k, cnt, m_words[k]);
      chk("state", k, st, exp_st);
   endtask

   // Per-cycle compare, write scoreboard, then model advance.
   always @(negedge clk) begin
      if (cmp_en) begin
         logic [38:0] e;
         cmp_dut(0, rdy0, we0, start0, busy0, err0, {25'd0, addr0}, data0, {24'd0, cnt0}, {30'd0, st0});
         cmp_dut(1, rdy1, we1, start1, busy1, err1, {30'd0, addr1}, data1, {29'd0, cnt1}, {30'd0, st1});
         if (we1) n_wr1++;
         if (we0) begin
            n_wr0++;
            if (sb_on) begin
               if (exp_q.size() == 0) begin
                  chk("sb_unexpected_write", 0, 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("sb_addr", 0, {25'd0, addr0}, {25'd0, e[38:32]});
                  chk("sb_data", 0, data0, e[31:0]);
               end
            end
         end
         model_step(0);
         model_step(1);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      sb_on = 1'b0;
      exp_q.delete();
      byte_valid = 1'b0;
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
   endtask

   // Offer one byte after a random gap; returns #1 after the edge that took it.
   task automatic send_byte(input logic [7:0] d, input logic l, input int max_gap);
      int  n;
      logic acc;
      repeat ($urandom_range(0, max_gap)) begin
         byte_valid = 1'b0;
         byte_data  = 8'($urandom);
         byte_last  = 1'($urandom_range(0, 1));
         idle(1);
      end
      byte_valid = 1'b1;
      byte_data  = d;
      byte_last  = l;
      n   = 0;
      acc = 1'b0;
      while (!acc && n <= 20) begin
         @(negedge clk);
         acc = rdy0;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("send_timeout", 0, 32'd0, 32'd1);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      byte_last  = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic l, input int max_gap);
      send_byte(w[31:24], 1'b0, max_gap);
      send_byte(w[23:16], 1'b0, max_gap);
      send_byte(w[15:8], 1'b0, max_gap);
      send_byte(w[7:0], l, max_gap);
   endtask

   initial begin
      int w0;
      int w1;
      int nw;
      bit partial;
      model_reset(0);
      model_reset(1);
      rst_n      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      byte_last  = 1'b0;
      @(posedge clk);
      #1;
      cmp_en = 1'b1;
      idle(1);
      // reset state
      chk("rst_ready", 0, {31'd0, rdy0}, 32'd1);
      chk("rst_start", 0, {31'd0, start0}, 32'd0);
      chk("rst_err", 0, {31'd0, err0}, 32'd0);
      chk("rst_count", 0, {24'd0, cnt0}, 32'd0);
      chk("rst_data", 0, data0, 32'd0);
      rst_n = 1'b1;

      // single word, back-to-back
      send_word(32'h2008000A, 1'b1, 0);
      chk("sw_we", 0, {31'd0, we0}, 32'd1);
      chk("sw_addr", 0, {25'd0, addr0}, 32'd0);
      chk("sw_data", 0, data0, 32'h2008000A);
      idle(1);
      chk("sw_start", 0, {31'd0, start0}, 32'd1);
      idle(3);
      chk("sw_start_held", 0, {31'd0, start0}, 32'd1);
      chk("sw_count", 0, {24'd0, cnt0}, 32'd1);
      chk("sw_err", 0, {31'd0, err0}, 32'd0);

      // input after DONE is ignored
      w0 = n_wr0;
      byte_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         byte_data = 8'($urandom);
         byte_last = 1'($urandom_range(0, 1));
         idle(1);
      end
      byte_valid = 1'b0;
      idle(1);
      chk("pd_writes", 0, n_wr0 - w0, 32'd0);
      chk("pd_ready", 0, {31'd0, rdy0}, 32'd0);
      chk("pd_count", 0, {24'd0, cnt0}, 32'd1);
      chk("pd_start", 0, {31'd0, start0}, 32'd1);

      // three words with gaps
      do_reset();
      sb_on = 1'b1;
      exp_q.push_back({7'd0, 32'h2008000A});
      exp_q.push_back({7'd1, 32'h20090003});
      exp_q.push_back({7'd2, 32'h01095020});
      w0 = n_wr0;
      send_word(32'h2008000A, 1'b0, 3);
      send_word(32'h20090003, 1'b0, 3);
      send_word(32'h01095020, 1'b1, 3);
      idle(3);
      chk("tw_sb_empty", 0, exp_q.size(), 32'd0);
      chk("tw_writes", 0, n_wr0 - w0, 32'd3);
      chk("tw_start", 0, {31'd0, start0}, 32'd1);
      chk("tw_count", 0, {24'd0, cnt0}, 32'd3);

      // partial word
      do_reset();
      w0 = n_wr0;
      send_byte(8'hAA, 1'b0, 1);
      send_byte(8'hBB, 1'b1, 1);
      idle(3);
      chk("pw_writes", 0, n_wr0 - w0, 32'd0);
      chk("pw_err", 0, {31'd0, err0}, 32'd1);
      chk("pw_start", 0, {31'd0, start0}, 32'd0);
      chk("pw_ready", 0, {31'd0, rdy0}, 32'd0);

      // overflow of the 4-word instance
      do_reset();
      w1 = n_wr1;
      for (int i = 0; i < 4; i++) send_word($urandom, 1'b0, 2);
      idle(3);
      chk("ov_writes", 1, n_wr1 - w1, 32'd4);
      chk("ov_err", 1, {31'd0, err1}, 32'd1);
      chk("ov_start", 1, {31'd0, start1}, 32'd0);
      chk("ov_count", 1, {29'd0, cnt1}, 32'd4);
      chk("ov_big_err", 0, {31'd0, err0}, 32'd0);

      // reset in the middle of a word
      do_reset();
      send_byte(8'h11, 1'b0, 0);
      send_byte(8'h22, 1'b0, 0);
      do_reset();
      sb_on = 1'b1;
      exp_q.push_back({7'd0, 32'h8C080004});
      send_word(32'h8C080004, 1'b1, 1);
      idle(3);
      chk("rm_sb_empty", 0, exp_q.size(), 32'd0);
      chk("rm_start", 0, {31'd0, start0}, 32'd1);

      // random programs, some ending mid-word
      for (int it = 0; it < 15; it++) begin
         do_reset();
         nw = $urandom_range(1, 6);
         partial = (it % 5) == 4;
         for (int i = 0; i < nw; i++)
            send_word($urandom, (!partial && i == nw - 1), $urandom_range(0, 3));
         if (partial) begin
            nw = $urandom_range(1, 3);
            for (int i = 0; i < nw; i++) send_byte(8'($urandom), (i == nw - 1), 2);
         end
         idle(4);
         chk("rnd_start", 0, {31'd0, start0}, {31'd0, !partial});
         chk("rnd_err", 0, {31'd0, err0}, {31'd0, partial});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
